// File: rtl/spsram_arb2.sv
// spsram_arb2 -- two-requester, zero-wait, round-robin arbiter in front of a
// single-port synchronous SRAM (spsram512x32) with a read latency of RD_LAT.
//
// Handshake: a requester holds mN_req with its we/addr/wdata. The access is
// accepted in any cycle where mN_req && mN_gnt. mN_gnt is combinational from
// the current requests, so an uncontended request is accepted in the cycle
// it appears. Dropping req before it is granted is harmless: nothing is
// queued here. A read returns as a single-cycle mN_rvalid exactly RD_LAT
// cycles after acceptance. mN_rdata is only meaningful while mN_rvalid is
// high.
//
// Parameters:
//   RD_LAT  SRAM read latency in clk cycles (1 or 2)
//   ADDR_W  word address width
//   DATA_W  data width
// Ports:
//   clk, rst                  clock, async active-low reset (0 = reset)
//   mN_req/we/addr/wdata      requester N access request (N = 0, 1)
//   mN_gnt                    requester N access accepted this cycle
//   mN_rvalid/rdata           requester N read return
//   mem_en/we/addr/din/dout   connection to the SRAM
//   busy                      at least one read is in flight
module spsram_arb2 #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  // Most recently granted requester; 1 after reset so m0 wins the first tie.
  logic              last_id;
  // Read-return pipeline: stage i holds a read accepted i+1 cycles ago.
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_id;

  logic              acc;
  logic              acc_id;
  logic              acc_rd;

  // Arbitration. Under contention the requester that did not win last time
  // wins now. All grants are forced low while in reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        m0_gnt = last_id;
        m1_gnt = ~last_id;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign acc    = m0_gnt | m1_gnt;
  assign acc_id = m1_gnt;

  // SRAM command mux; all-zero when idle.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (m0_gnt) begin
      mem_en   = 1'b1;
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
    end else if (m1_gnt) begin
      mem_en   = 1'b1;
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
    end
  end

  assign acc_rd = acc & ~mem_we;

  // Reset discards any reads in flight, so no stale rvalid can follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_id <= 1'b1;
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      if (acc) last_id <= acc_id;
      pipe_v[0]  <= acc_rd;
      pipe_id[0] <= acc_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  // The last stage lines up with the SRAM output; only one read per cycle can
  // sit there, so the two rvalids are mutually exclusive by construction.
  assign m0_rvalid = rst & pipe_v[RD_LAT-1] & ~pipe_id[RD_LAT-1];
  assign m1_rvalid = rst & pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];
  assign m0_rdata  = rst ? mem_dout : '0;
  assign m1_rdata  = rst ? mem_dout : '0;
  assign busy      = rst & (|pipe_v);

endmodule

// File: tb/tb_spsram_arb2.sv
module tb_spsram_arb2;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W  = 65;  // {accept cycle[31:0], id, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic nxt_rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;

  // ---------------- DUT with RD_LAT = 1 (a_*) ----------------
  logic          a_g0, a_g1, a_rv0, a_rv1, a_en, a_we, a_busy;
  logic [DW-1:0] a_rd0, a_rd1, a_din, a_dout;
  logic [AW-1:0] a_addr;

  spsram_arb2 #(.RD_LAT(1), .ADDR_W(AW), .DATA_W(DW)) u1 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_g0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_g1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_din(a_din),
    .mem_dout(a_dout), .busy(a_busy)
  );

  // ---------------- DUT with RD_LAT = 2 (b_*) ----------------
  logic          b_g0, b_g1, b_rv0, b_rv1, b_en, b_we, b_busy;
  logic [DW-1:0] b_rd0, b_rd1, b_din, b_dout;
  logic [AW-1:0] b_addr;

  spsram_arb2 #(.RD_LAT(2), .ADDR_W(AW), .DATA_W(DW)) u2 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_g0), .m0_rvalid(b_rv0), .m0_rdata(b_rd0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_g1), .m1_rvalid(b_rv1), .m1_rdata(b_rd1),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_din(b_din),
    .mem_dout(b_dout), .busy(b_busy)
  );

  // ---------------- attached SRAMs (latency 1 and 2) ----------------
  function automatic logic [DW-1:0] pre(input int i);
    return 32'hC0DE0000 | DW'(i);
  endfunction

  logic [DW-1:0] sram1 [512];
  logic [DW-1:0] sram2 [512];
  logic [DW-1:0] s2_q;

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram1[i] <= pre(i);
      sram2[i] <= pre(i);
    end
  end

  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) sram1[a_addr] <= a_din;
      else      a_dout <= sram1[a_addr];
    end
    if (b_en) begin
      if (b_we) sram2[b_addr] <= b_din;
      else      s2_q <= sram2[b_addr];
    end
    b_dout <= s2_q;
  end

  // ---------------- scoreboard / reference model ----------------
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            wait0 = 0, wait1 = 0;
  logic          m_last = 1'b1;
  logic [DW-1:0] shadow [512];
  logic [W-1:0]  exp_q[$];
  logic          e_g0, e_g1, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs of a latency-`lat` instance: reads come back `lat`
  // cycles after acceptance, busy covers the cycles in between.
  task automatic check_inst(input int lat, input string tag,
                            input logic g0, input logic g1,
                            input logic rv0, input logic rv1, input logic bz,
                            input logic en, input logic we,
                            input logic [AW-1:0] ad, input logic [DW-1:0] din,
                            input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    logic          found;
    logic          fid;
    logic          eb;
    logic [DW-1:0] fdat;
    int            acc;
    found = 1'b0; fid = 1'b0; eb = 1'b0; fdat = '0;
    if (!rst) begin
      chk({tag, "_rst_gnt0"}, 64'(g0), 64'(0));
      chk({tag, "_rst_gnt1"}, 64'(g1), 64'(0));
      chk({tag, "_rst_rv"}, 64'({rv0, rv1}), 64'(0));
      chk({tag, "_rst_busy"}, 64'(bz), 64'(0));
      chk({tag, "_rst_mem"}, 64'({en, we, ad}), 64'(0));
      chk({tag, "_rst_din"}, 64'(din), 64'(0));
      chk({tag, "_rst_rdata"}, {rd0, rd1}, 64'(0));
    end else begin
      foreach (exp_q[i]) begin
        acc = int'(exp_q[i][64:33]);
        if (acc + lat == cyc) begin
          found = 1'b1;
          fid   = exp_q[i][32];
          fdat  = exp_q[i][31:0];
        end
        if (cyc <= acc + lat) eb = 1'b1;
      end
      chk({tag, "_gnt0"}, 64'(g0), 64'(e_g0));
      chk({tag, "_gnt1"}, 64'(g1), 64'(e_g1));
      chk({tag, "_mem_en"}, 64'(en), 64'(e_g0 | e_g1));
      chk({tag, "_mem_we"}, 64'(we), 64'(e_we));
      chk({tag, "_mem_addr"}, 64'(ad), 64'(e_addr));
      chk({tag, "_mem_din"}, 64'(din), 64'(e_din));
      chk({tag, "_rvalid0"}, 64'(rv0), 64'(found & ~fid));
      chk({tag, "_rvalid1"}, 64'(rv1), 64'(found & fid));
      chk({tag, "_busy"}, 64'(bz), 64'(eb));
      if (found) chk({tag, "_rdata"}, 64'(fid ? rd1 : rd0), 64'(fdat));
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        if (m_last) e_g0 = 1'b1; else e_g1 = 1'b1;
      end else if (m0_req) e_g0 = 1'b1;
      else if (m1_req) e_g1 = 1'b1;
    end
    e_we   = e_g0 ? m0_we    : (e_g1 ? m1_we    : 1'b0);
    e_addr = e_g0 ? m0_addr  : (e_g1 ? m1_addr  : '0);
    e_din  = e_g0 ? m0_wdata : (e_g1 ? m1_wdata : '0);

    check_inst(1, "L1", a_g0, a_g1, a_rv0, a_rv1, a_busy, a_en, a_we, a_addr, a_din, a_rd0, a_rd1);
    check_inst(2, "L2", b_g0, b_g1, b_rv0, b_rv1, b_busy, b_en, b_we, b_addr, b_din, b_rd0, b_rd1);

    if (rst) begin
      if (m0_req && !a_g0) wait0++; else wait0 = 0;
      if (m1_req && !a_g1) wait1++; else wait1 = 0;
      chk("wait0_le1", 64'(wait0 <= 1), 64'(1));
      chk("wait1_le1", 64'(wait1 <= 1), 64'(1));
      chk("one_gnt", 64'(a_g0 & a_g1), 64'(0));
    end

    if (!rst) begin
      exp_q.delete();
      m_last = 1'b1;
      wait0 = 0;
      wait1 = 0;
    end else begin
      while (exp_q.size() > 0 && int'(exp_q[0][64:33]) + 2 <= cyc) void'(exp_q.pop_front());
      if (e_g0 || e_g1) begin
        m_last = e_g1;
        if (e_we) shadow[e_addr] = e_din;
        else exp_q.push_back({cyc[31:0], e_g1, shadow[e_addr]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    rst = nxt_rst;
    m0_req = r0; m0_we = w0; m0_addr = ad0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = ad1; m1_wdata = d1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- directed scenarios, then random ----------------
  initial begin
    logic          r0, w0, r1, w1;
    logic [AW-1:0] ad0, ad1;
    logic [DW-1:0] d0, d1;

    for (int i = 0; i < 512; i++) shadow[i] = pre(i);

    // Reset held with both requesting: nothing may be granted.
    nxt_rst = 1'b0;
    step(1'b1, 1'b0, 9'd1, '0, 1'b1, 1'b0, 9'd2, '0);
    chk("rst_gnt", 64'({a_g0, a_g1, b_g0, b_g1}), 64'(0));
    chk("rst_busy", 64'({a_busy, b_busy}), 64'(0));
    chk("rst_mem_en", 64'({a_en, b_en}), 64'(0));

    // Simultaneous requests for 4 cycles after release: m0, m1, m0, m1.
    nxt_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, AW'(k), '0, 1'b1, 1'b0, AW'(k + 8), '0);
      chk("s35_gnt0", 64'(a_g0), 64'(k % 2 == 0));
      chk("s35_gnt1", 64'(a_g1), 64'(k % 2 == 1));
      chk("s35_gnt0_l2", 64'(b_g0), 64'(k % 2 == 0));
    end
    idle(); idle(); idle();

    // m0 writes then reads 0x005: data back after RD_LAT cycles.
    step(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 9'h005, '0, 1'b0, 1'b0, '0, '0);
    chk("s36_rd_gnt", 64'(b_g0), 64'(1));
    idle();
    chk("s36_l2_rv0_early", 64'(b_rv0), 64'(0));
    chk("s36_l1_rv0", 64'(a_rv0), 64'(1));
    chk("s36_l1_rdata", 64'(a_rd0), 64'(32'hDEADBEEF));
    idle();
    chk("s36_l2_rv0", 64'(b_rv0), 64'(1));
    chk("s36_l2_rdata", 64'(b_rd0), 64'(32'hDEADBEEF));
    chk("s36_l2_rv1", 64'(b_rv1), 64'(0));
    idle();
    chk("s36_l2_rv0_once", 64'(b_rv0), 64'(0));

    // Alternating m0 @0x000 / m1 @0x1FF reads; latency-1 returns next cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step(1'b1, 1'b0, 9'h000, '0, 1'b0, 1'b0, '0, '0);
      else            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h1FF, '0);
      if (k > 0) begin
        if (k % 2 == 1) begin
          chk("s37_rv0", 64'({a_rv0, a_rv1}), 64'(2'b10));
          chk("s37_rd0", 64'(a_rd0), 64'(32'hC0DE0000));
        end else begin
          chk("s37_rv1", 64'({a_rv0, a_rv1}), 64'(2'b01));
          chk("s37_rd1", 64'(a_rd1), 64'(32'hC0DE01FF));
        end
      end
    end
    idle();
    chk("s37_last_rv1", 64'({a_rv0, a_rv1}), 64'(2'b01));
    chk("s37_last_rd1", 64'(a_rd1), 64'(32'hC0DE01FF));
    idle(); idle();

    // Only m1 requests for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(9'h40 + k), DW'(k));
      chk("s38_gnt1", 64'(a_g1), 64'(1));
      chk("s38_gnt0", 64'(a_g0), 64'(0));
    end
    idle();
    chk("s38_last_id", 64'(u1.last_id), 64'(1));
    step(1'b1, 1'b1, 9'h50, '0, 1'b1, 1'b1, 9'h51, '0);
    chk("s38_tie_gnt0", 64'({a_g0, a_g1}), 64'(2'b10));

    // m0 read accepted, then reset for 2 cycles: that read never returns.
    step(1'b1, 1'b0, 9'h003, '0, 1'b0, 1'b0, '0, '0);
    chk("s39_rd_gnt", 64'(a_g0), 64'(1));
    nxt_rst = 1'b0;
    idle();
    chk("s39_rv0_a", 64'({a_rv0, b_rv0}), 64'(0));
    idle();
    chk("s39_rv0_b", 64'({a_rv0, b_rv0}), 64'(0));
    nxt_rst = 1'b1;
    step(1'b1, 1'b1, 9'h20, 32'h1, 1'b1, 1'b1, 9'h21, 32'h2);
    chk("s39_tie_gnt0", 64'({a_g0, a_g1}), 64'(2'b10));
    chk("s39_busy", 64'({a_busy, b_busy}), 64'(0));
    idle();
    chk("s39_rv0_c", 64'({a_rv0, b_rv0}), 64'(0));
    idle();
    chk("s39_rv0_d", 64'({a_rv0, b_rv0}), 64'(0));

    // Random traffic with occasional resets; the model checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      r0  = ($urandom_range(0, 99) < 60);
      r1  = ($urandom_range(0, 99) < 60);
      w0  = ($urandom_range(0, 2) == 0);
      w1  = ($urandom_range(0, 2) == 0);
      ad0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 511)) : AW'($urandom_range(0, 7));
      ad1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 511)) : AW'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      nxt_rst = ($urandom_range(0, 499) != 0);
      step(r0, w0, ad0, d0, r1, w1, ad1, d1);
    end
    nxt_rst = 1'b1;
    idle(); idle(); idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
